// File: rtl/alu_cmd_feeder.sv
// Command FIFO feeding a registered-input 4-bit ALU, with a latency-matched tag
// pipeline that labels each returning ALU result with its opcode and sequence number.
module alu_cmd_feeder #(
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 1,
  parameter int SEQ_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_opcode,
  input  logic [3:0]              in_a,
  input  logic [3:0]              in_b,
  input  logic                    hold,
  output logic [1:0]              alu_opcode,
  output logic [3:0]              alu_a,
  output logic [3:0]              alu_b,
  output logic                    alu_issue,
  input  logic [4:0]              alu_c,
  output logic                    res_valid,
  output logic [1:0]              res_opcode,
  output logic [4:0]              res_c,
  output logic [SEQ_W-1:0]        res_seq,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 10;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic [SEQ_W-1:0] seq_reg;
  logic             push;
  logic             pop;

  logic [1:0]       alu_opcode_reg;
  logic [3:0]       alu_a_reg;
  logic [3:0]       alu_b_reg;
  logic             alu_issue_reg;
  logic [SEQ_W-1:0] alu_seq_reg;

  // Ready is a pure decode of the registered occupancy, so a pop never frees a slot early.
  assign in_ready = (count_reg < FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (count_reg != '0) && !hold;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_opcode, in_a, in_b};
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      seq_reg    <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        seq_reg    <= seq_reg + 1'b1;
      end
    end
  end

  // Head entry is read straight into the ALU operand registers; idle cycles drive zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_issue_reg  <= 1'b0;
      alu_seq_reg    <= '0;
    end else if (pop) begin
      {alu_opcode_reg, alu_a_reg, alu_b_reg} <= mem[rd_ptr_reg];
      alu_issue_reg  <= 1'b1;
      alu_seq_reg    <= seq_reg;
    end else begin
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_issue_reg  <= 1'b0;
      alu_seq_reg    <= '0;
    end
  end

  // Tag pipeline: stage 0 captures the issued tag on the same edge the ALU captures its
  // operands, so the last stage lines up with the cycle alu_c carries that result.
  genvar gi;
  generate
    for (gi = 0; gi < ALU_LAT; gi++) begin : g_pipe
      logic             valid_reg;
      logic [1:0]       op_reg;
      logic [SEQ_W-1:0] seq_tag_reg;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            valid_reg   <= 1'b0;
            op_reg      <= '0;
            seq_tag_reg <= '0;
          end else begin
            valid_reg   <= alu_issue_reg;
            op_reg      <= alu_opcode_reg;
            seq_tag_reg <= alu_seq_reg;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            valid_reg   <= 1'b0;
            op_reg      <= '0;
            seq_tag_reg <= '0;
          end else begin
            valid_reg   <= g_pipe[gi-1].valid_reg;
            op_reg      <= g_pipe[gi-1].op_reg;
            seq_tag_reg <= g_pipe[gi-1].seq_tag_reg;
          end
        end
      end
    end
  endgenerate

  assign alu_opcode = alu_opcode_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_issue  = alu_issue_reg;
  assign count      = count_reg;

  assign res_valid  = g_pipe[ALU_LAT-1].valid_reg;
  assign res_opcode = g_pipe[ALU_LAT-1].op_reg;
  assign res_seq    = g_pipe[ALU_LAT-1].seq_tag_reg;
  assign res_c      = res_valid ? alu_c : '0;

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Directed bench for alu_cmd_feeder with a behavioural registered 4-bit ALU attached
// to the issue port; every comparison is an immediate assertion.
module tb_alu_cmd_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_opcode;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        hold;
  logic [1:0]  alu_opcode;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_issue;
  logic [4:0]  alu_c = '0;
  logic        res_valid;
  logic [1:0]  res_opcode;
  logic [4:0]  res_c;
  logic [7:0]  res_seq;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  alu_cmd_feeder #(.DEPTH(8), .ALU_LAT(1), .SEQ_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .hold       (hold),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_issue  (alu_issue),
    .alu_c      (alu_c),
    .res_valid  (res_valid),
    .res_opcode (res_opcode),
    .res_c      (res_c),
    .res_seq    (res_seq),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] ea;
    logic [4:0] eb;
    ea = {a[3], a};
    eb = {b[3], b};
    case (op)
      2'b00:   return ea + eb;
      2'b01:   return ea - eb;
      2'b10:   return ~ea;
      default: return {4'b0000, |b};
    endcase
  endfunction

  // Registered ALU: captures operands on an edge, result valid until the next edge.
  always @(posedge clk) alu_c <= alu_f(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] t_op [9];
  logic [3:0] t_a  [9];
  logic [3:0] t_b  [9];
  logic [4:0] t_c  [9];
  logic [9:0] q [$];
  logic [9:0] exp_cmd;
  logic [1:0] w_op;
  logic [3:0] w_a;
  logic [3:0] w_b;

  initial begin
    // Drain table: opcode, A, B, hand-computed C
    t_op[0] = 2'b01; t_a[0] = 4'h7; t_b[0] = 4'h8; t_c[0] = 5'h0F; // 7-(-8)=15
    t_op[1] = 2'b01; t_a[1] = 4'h8; t_b[1] = 4'h7; t_c[1] = 5'h11; // -8-7=-15
    t_op[2] = 2'b10; t_a[2] = 4'h7; t_b[2] = 4'h0; t_c[2] = 5'h18; // ~7=-8
    t_op[3] = 2'b11; t_a[3] = 4'h0; t_b[3] = 4'h8; t_c[3] = 5'h01; // |B=1
    t_op[4] = 2'b00; t_a[4] = 4'h8; t_b[4] = 4'h8; t_c[4] = 5'h10; // -16
    t_op[5] = 2'b00; t_a[5] = 4'h7; t_b[5] = 4'h7; t_c[5] = 5'h0E; // 14
    t_op[6] = 2'b10; t_a[6] = 4'hF; t_b[6] = 4'h3; t_c[6] = 5'h00; // ~(-1)=0
    t_op[7] = 2'b11; t_a[7] = 4'h5; t_b[7] = 4'h0; t_c[7] = 5'h00; // |0=0
    t_op[8] = 2'b00; t_a[8] = 4'h1; t_b[8] = 4'h1; t_c[8] = 5'h02; // 2

    reset = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; hold = 1'b0;

    // Reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_issue", 32'(alu_issue), 32'd0);
    chk("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    chk("rst_res", 32'({res_valid, res_opcode, res_c, res_seq}), 32'd0);
    @(negedge clk); reset = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single command (00,7,7)
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 2'b00; in_a = 4'h7; in_b = 4'h7;
    @(negedge clk); in_valid = 1'b0;
    chk("single_count", 32'(count), 32'd1);
    chk("single_no_bypass", 32'(alu_issue), 32'd0);
    @(negedge clk);
    chk("single_issue", 32'(alu_issue), 32'd1);
    chk("single_ops", 32'({alu_opcode, alu_a, alu_b}), 32'({2'b00, 4'h7, 4'h7}));
    chk("single_res_early", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("single_res_valid", 32'(res_valid), 32'd1);
    chk("single_res", 32'({res_opcode, res_c, res_seq}), 32'({2'b00, 5'd14, 8'd0}));
    @(negedge clk);
    chk("single_res_gone", 32'({res_valid, res_c}), 32'd0);

    // Reset mid-operation: 3 queued, one just issued
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_opcode = 2'(i); in_a = 4'(i + 1); in_b = 4'(i + 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midrst_count3", 32'(count), 32'd3);
    hold = 1'b0;
    @(negedge clk);
    chk("midrst_issue", 32'(alu_issue), 32'd1);
    reset = 1'b0; hold = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_alu_issue", 32'(alu_issue), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk); reset = 1'b1;
    #1 chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'({res_valid, alu_issue}), 32'd0);
    end

    // Fill with hold=1; 9th command is refused and stays offered
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_opcode = t_op[i]; in_a = t_a[i]; in_b = t_b[i];
      @(negedge clk);
      chk("fill_count", 32'(count), (i < 8) ? 32'(i + 1) : 32'd8);
      if (i >= 7) chk("fill_in_ready", 32'(in_ready), 32'd0);
    end

    // Drain: 9 back-to-back issues (held command enters after the first pop)
    hold = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j < 9) begin
        chk("drain_issue", 32'(alu_issue), 32'd1);
        chk("drain_ops", 32'({alu_opcode, alu_a, alu_b}), 32'({t_op[j], t_a[j], t_b[j]}));
      end else begin
        chk("drain_idle", 32'(alu_issue), 32'd0);
      end
      if (j == 0) begin
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        chk("drain_res_none", 32'(res_valid), 32'd0);
      end else begin
        chk("drain_res_valid", 32'(res_valid), 32'd1);
        chk("drain_res", 32'({res_opcode, res_c, res_seq}), 32'({t_op[j-1], t_c[j-1], 8'(j - 1)}));
      end
      if (j == 1) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("drain_done", 32'({res_valid, res_c, count}), 32'd0);

    // Simultaneous push/pop at count=4 across pointer wrap
    hold = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_opcode = 2'(i); in_a = 4'(i * 3); in_b = 4'(i * 5 + 1);
      q.push_back({in_opcode, in_a, in_b});
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pp_count4", 32'(count), 32'd4);
    hold = 1'b0;
    for (int i = 4; i < 24; i++) begin
      in_valid = 1'b1; in_opcode = 2'(i); in_a = 4'(i * 3); in_b = 4'(i * 5 + 1);
      q.push_back({in_opcode, in_a, in_b});
      @(negedge clk);
      exp_cmd = q.pop_front();
      chk("pp_count", 32'(count), 32'd4);
      chk("pp_issue", 32'(alu_issue), 32'd1);
      chk("pp_order", 32'({alu_opcode, alu_a, alu_b}), 32'(exp_cmd));
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_cmd = q.pop_front();
      chk("pp_tail_issue", 32'(alu_issue), 32'd1);
      chk("pp_tail_order", 32'({alu_opcode, alu_a, alu_b}), 32'(exp_cmd));
    end
    @(negedge clk);
    chk("pp_empty", 32'({alu_issue, count}), 32'd0);

    // Sequence wrap: 257 streamed commands after a fresh reset
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int j = 0; j < 259; j++) begin
      if (j < 257) begin
        in_valid = 1'b1; in_opcode = 2'(j); in_a = 4'(j); in_b = 4'(j * 5);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (j >= 2) begin
        w_op = 2'(j - 2); w_a = 4'(j - 2); w_b = 4'((j - 2) * 5);
        chk("wrap_res_valid", 32'(res_valid), 32'd1);
        chk("wrap_res", 32'({res_opcode, res_c, res_seq}), 32'({w_op, alu_f(w_op, w_a, w_b), 8'(j - 2)}));
      end
    end
    @(negedge clk);
    chk("wrap_end", 32'(res_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
